qsq_mult_arbiter: RTL and testbench

Controller that shares one registered quarter-square lookup table (Q = floor(Addr²/4), one-cycle read latency) between two multiply requesters. Each operation computes A×B = floor((A+B)²/4) − floor(|A−B|²/4) with two sequenced table reads and one subtraction. It sits between the requesting pipeline stages and the single LUT instance, and owns round-robin arbitration, address sequencing and result delivery.

---
 rtl/qsq_mult_arbiter.sv | 127 ++++++++++++
 tb/tb_qsq_mult_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/qsq_mult_arbiter.sv
// Shares one registered quarter-square LUT between two multiply requesters.
// A*B = Q(A+B) - Q(|A-B|), with round-robin arbitration between requesters.
module qsq_mult_arbiter (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        Req0,
   input  logic [6:0]  A0,
   input  logic [6:0]  B0,
   input  logic        Req1,
   input  logic [6:0]  A1,
   input  logic [6:0]  B1,
   output logic [7:0]  Lut_Addr,
   input  logic [15:0] Lut_Q,
   output logic [15:0] Product,
   output logic        Done0,
   output logic        Done1
);

   localparam int unsigned OP_W   = 7;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SUM  = 3'd1,
      DIFF = 3'd2,
      CALC = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     ra_q, ra_d;
   logic [OP_W-1:0]     rb_q, rb_d;
   logic [DATA_W-1:0]   rsq_q, rsq_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   prod_q, prod_d;
   logic                done0_q, done0_d;
   logic                done1_q, done1_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                grant1;

   // State and datapath registers; last-served resets to requester 1
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rsq_q   <= '0;
         addr_q  <= '0;
         prod_q  <= '0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rsq_q   <= rsq_d;
         addr_q  <= addr_d;
         prod_q  <= prod_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Requester 1 wins if alone, or on a tie when requester 0 was served last
   assign grant1 = Req1 & (~Req0 | ~last_q);

   // Next-state and sequencing of the two table reads
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rsq_d   = rsq_q;
      addr_d  = addr_q;
      prod_d  = prod_q;
      done0_d = 1'b0;
      done1_d = 1'b0;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               ra_d    = grant1 ? A1 : A0;
               rb_d    = grant1 ? B1 : B0;
               addr_d  = grant1 ? (ADDR_W'(A1) + ADDR_W'(B1)) : (ADDR_W'(A0) + ADDR_W'(B0));
               owner_d = grant1;
               state_d = SUM;
            end
         end
         SUM: begin
            addr_d  = (ra_q >= rb_q) ? ADDR_W'(ra_q - rb_q) : ADDR_W'(rb_q - ra_q);
            state_d = DIFF;
         end
         DIFF: begin
            rsq_d   = Lut_Q;
            addr_d  = '0;
            state_d = CALC;
         end
         CALC: begin
            prod_d  = rsq_q - Lut_Q;
            done0_d = ~owner_q;
            done1_d = owner_q;
            last_d  = owner_q;
            state_d = DONE;
         end
         DONE: begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: begin
            addr_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign Lut_Addr = addr_q;
   assign Product  = prod_q;
   assign Done0    = done0_q;
   assign Done1    = done1_q;

endmodule

// File: tb/tb_qsq_mult_arbiter.sv
// Bench for qsq_mult_arbiter: LUT model, timeline-based reference model,
// directed test-plan cases and a randomized two-requester sweep.
module tb_qsq_mult_arbiter;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b1;
   logic        Req0 = 1'b0, Req1 = 1'b0;
   logic [6:0]  A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic [7:0]  Lut_Addr;
   logic [15:0] Lut_Q = '0;
   logic [15:0] Product;
   logic        Done0, Done1;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   qsq_mult_arbiter dut (
      .CLK(CLK), .RSTn(RSTn),
      .Req0(Req0), .A0(A0), .B0(B0),
      .Req1(Req1), .A1(A1), .B1(B1),
      .Lut_Addr(Lut_Addr), .Lut_Q(Lut_Q),
      .Product(Product), .Done0(Done0), .Done1(Done1)
   );

   always #5 CLK = ~CLK;

   // Shared quarter-square table, one-cycle read latency
   always @(posedge CLK) Lut_Q <= 16'((int'(Lut_Addr) * int'(Lut_Addr)) / 4);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: once granted, an operation follows a fixed 5-edge timeline
   int          m_busy = 0, m_cnt = 0, m_own = 0, m_last = 1, m_a = 0, m_b = 0, m_ops = 0;
   logic [7:0]  m_addr = '0;
   logic [15:0] m_prod = '0;
   logic        m_d0 = 1'b0, m_d1 = 1'b0;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         m_busy = 0; m_cnt = 0; m_last = 1;
         m_addr = '0; m_prod = '0; m_d0 = 1'b0; m_d1 = 1'b0;
      end else begin
         m_d0 = 1'b0;
         m_d1 = 1'b0;
         if (m_busy == 0) begin
            if (Req0 || Req1) begin
               if (Req0 && Req1) m_own = (m_last == 1) ? 0 : 1;
               else              m_own = Req0 ? 0 : 1;
               m_a    = (m_own == 1) ? int'(A1) : int'(A0);
               m_b    = (m_own == 1) ? int'(B1) : int'(B0);
               m_addr = 8'(m_a + m_b);
               m_busy = 1;
               m_cnt  = 0;
            end
         end else begin
            m_cnt++;
            case (m_cnt)
               1: m_addr = 8'((m_a > m_b) ? m_a - m_b : m_b - m_a);
               2: m_addr = '0;
               3: begin
                  m_prod = 16'(m_a * m_b);
                  if (m_own == 1) m_d1 = 1'b1; else m_d0 = 1'b1;
                  m_last = m_own;
                  m_ops++;
               end
               default: m_busy = 0;
            endcase
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check_eq("lut_addr", 32'(Lut_Addr), 32'(m_addr));
         check_eq("product", 32'(Product), 32'(m_prod));
         check_eq("done0", 32'(Done0), 32'(m_d0));
         check_eq("done1", 32'(Done1), 32'(m_d1));
      end
   end

   task automatic drive(input int who, input logic r, input int a, input int b);
      if (who == 0) begin Req0 = r; A0 = 7'(a); B0 = 7'(b); end
      else          begin Req1 = r; A1 = 7'(a); B1 = 7'(b); end
   endtask

   // One operation; mode 1 changes operands after grant, mode 2 drops Req in DIFF
   task automatic single_op(input int who, input int a, input int b, input int mode, input int exp);
      int k, done_k, addr1, addr2;
      logic [15:0] p;
      logic d;
      k = 0; done_k = 0; addr1 = 0; addr2 = 0; p = '0;
      drive(who, 1'b1, a, b);
      while (done_k == 0 && k < 10) begin
         @(negedge CLK);
         k++;
         if (k == 1) addr1 = int'(Lut_Addr);
         if (k == 2) addr2 = int'(Lut_Addr);
         if (mode == 1 && k == 1) drive(who, 1'b1, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
         if (mode == 2 && k == 2) drive(who, 1'b0, a, b);
         d = (who == 1) ? Done1 : Done0;
         if (d) begin done_k = k; p = Product; end
      end
      drive(who, 1'b0, a, b);
      check_eq("op_latency", 32'(done_k), 32'd4);
      check_eq("op_prod", 32'(p), 32'(exp));
      check_eq("op_sum_addr", 32'(addr1), 32'(a + b));
      check_eq("op_diff_addr", 32'(addr2), 32'((a > b) ? a - b : b - a));
      @(negedge CLK);
   endtask

   // Both requesters held high: owners alternate starting with requester 0
   task automatic tie_run(input int n);
      int k, seen, last_k, owner;
      k = 0; seen = 0; last_k = 0;
      A0 = 7'd3; B0 = 7'd10; A1 = 7'd7; B1 = 7'd9;
      Req0 = 1'b1; Req1 = 1'b1;
      while (seen < n && k < 12 * n) begin
         @(negedge CLK);
         k++;
         if (Done0 || Done1) begin
            owner = Done1 ? 1 : 0;
            check_eq("tie_owner", 32'(owner), 32'(seen % 2));
            check_eq("tie_prod", 32'(Product), (seen % 2 == 1) ? 32'd63 : 32'd30);
            check_eq("tie_gap", 32'(k - last_k), (seen == 0) ? 32'd4 : 32'd5);
            last_k = k;
            seen++;
         end
      end
      check_eq("tie_count", 32'(seen), 32'(n));
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic rand_req(input int who, input logic done);
      logic r;
      r = (who == 1) ? Req1 : Req0;
      if (done)                             r = ($urandom_range(0, 3) != 0);
      else if (!r)                          r = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 31) == 0)  r = 1'b0;
      if ($urandom_range(0, 1) == 0)
         drive(who, r, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      else if (who == 1)
         Req1 = r;
      else
         Req0 = r;
   endtask

   initial begin
      int ops0, cyc;
      #1 RSTn = 1'b0;
      repeat (3) @(negedge CLK);
      check_eq("rst_addr", 32'(Lut_Addr), 32'd0);
      check_eq("rst_prod", 32'(Product), 32'd0);
      check_eq("rst_done0", 32'(Done0), 32'd0);
      check_eq("rst_done1", 32'(Done1), 32'd0);
      chk_en = 1'b1;
      RSTn   = 1'b1;

      tie_run(6);

      single_op(0, 12, 5, 0, 60);
      single_op(1, 127, 127, 0, 16129);
      single_op(1, 0, 99, 0, 0);
      single_op(0, 20, 30, 1, 600);
      single_op(0, 9, 11, 2, 99);

      // Reset while the operation sits in CALC
      drive(0, 1'b1, 50, 2);
      repeat (3) @(negedge CLK);
      #1 RSTn = 1'b0;
      Req0 = 1'b0;
      repeat (2) begin
         @(negedge CLK);
         check_eq("midrst_done0", 32'(Done0), 32'd0);
         check_eq("midrst_prod", 32'(Product), 32'd0);
         check_eq("midrst_addr", 32'(Lut_Addr), 32'd0);
      end
      RSTn = 1'b1;
      tie_run(2);

      // Every table index as a sum (0..254) and as a difference (0..127)
      for (int s = 0; s <= 254; s++) single_op(s % 2, (s + 1) / 2, s / 2, 0, ((s + 1) / 2) * (s / 2));
      for (int d = 0; d <= 127; d++) single_op(d % 2, 127, 127 - d, 0, 127 * (127 - d));

      ops0 = m_ops;
      cyc  = 0;
      while (m_ops - ops0 < 10000 && cyc < 75000) begin
         @(negedge CLK);
         cyc++;
         rand_req(0, Done0);
         rand_req(1, Done1);
      end
      check_eq("sweep_ops", 32'(m_ops - ops0), 32'd10000);
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (8) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
